// File: rtl/operand_load_ctrl.sv
// Operand load controller: captures two bytes into operand registers A and B,
// starts the compute unit and waits for completion or a timeout.
module operand_load_ctrl #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] reg_data,
    output logic       ld_a,
    output logic       ld_b,
    output logic       op_start,
    input  logic       op_done,
    output logic       done,
    output logic       busy,
    output logic       err,
    input  logic       err_clr
);

    typedef enum logic [2:0] {
        S_A,
        S_LDA,
        S_B,
        S_LDB,
        S_GO,
        S_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] reg_data_q, reg_data_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic       transfer;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A;
            reg_data_q <= 8'h00;
            wait_cnt_q <= 8'h00;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_data_q <= reg_data_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign transfer = in_valid && in_ready;

    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        reg_data_d = reg_data_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;

        // Clear is applied first so a timeout on the same edge overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_A: begin
                if (transfer) begin
                    reg_data_d = in_data;
                    state_d    = S_LDA;
                end
            end
            S_LDA: state_d = S_B;
            S_B: begin
                if (transfer) begin
                    reg_data_d = in_data;
                    state_d    = S_LDB;
                end
            end
            S_LDB: state_d = S_GO;
            S_GO: begin
                wait_cnt_d = 8'h00;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (op_done) begin
                    state_d = S_A;
                    done_d  = 1'b1;
                end else if (wait_cnt_q == TIMEOUT - 8'd1) begin
                    state_d = S_A;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_A;
        endcase
    end

    // Moore outputs; in_ready is held low during reset so no byte is lost.
    assign in_ready = !rst && ((state_q == S_A) || (state_q == S_B));
    assign ld_a     = (state_q == S_LDA);
    assign ld_b     = (state_q == S_LDB);
    assign op_start = (state_q == S_GO);
    assign busy     = (state_q != S_A);
    assign reg_data = reg_data_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_operand_load_ctrl.sv
// Directed bench for operand_load_ctrl: load bytes queued as expected strobes
// and popped when ld_a/ld_b are observed.
module tb_operand_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] reg_data;
    logic       ld_a;
    logic       ld_b;
    logic       op_start;
    logic       op_done;
    logic       done;
    logic       busy;
    logic       err;
    logic       err_clr;

    typedef struct packed {
        logic       is_b;
        logic [7:0] data;
    } ld_exp_t;

    ld_exp_t exp_q[$];
    int      n_assert = 0;
    int      n_fail   = 0;
    int      n_start  = 0;
    int      n_done   = 0;

    operand_load_ctrl #(.TIMEOUT(8'd5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reg_data (reg_data),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .op_start (op_start),
        .op_done  (op_done),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge.
    task automatic tick();
        ld_exp_t got;
        @(posedge clk);
        #1;
        check("strobe_excl", 32'({ld_a, ld_b, op_start} inside {3'b000, 3'b001, 3'b010, 3'b100}), 32'd1);
        if (op_start) n_start++;
        if (done) n_done++;
        if (ld_a || ld_b) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                got = '{is_b: ld_b, data: reg_data};
                check("ld_strobe_data", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // Send bytes a and b back to back and stop in S_WAIT, checking latency.
    task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = a;
        exp_q.push_back('{is_b: 1'b0, data: a});
        tick();
        check("ld_a_k+1", 32'(ld_a), 32'd1);
        check("ready_lda", 32'(in_ready), 32'd0);
        in_data = b;
        exp_q.push_back('{is_b: 1'b1, data: b});
        tick();
        check("ready_s_b", 32'(in_ready), 32'd1);
        tick();
        check("ld_b_m+1", 32'(ld_b), 32'd1);
        in_valid = 1'b0;
        tick();
        check("op_start_m+2", 32'(op_start), 32'd1);
        tick();
        check("wait_m+3_busy", 32'(busy), 32'd1);
        check("wait_m+3_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        op_done  = 1'b0;
        err_clr  = 1'b0;

        // Reset: in_ready gated while rst is high, then quiet outputs.
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_outs", 32'({ld_a, ld_b, op_start, busy, done, err}), 32'd0);
        check("post_rst_reg", 32'(reg_data), 32'h00);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Normal operation, op_done 4 cycles after op_start.
        n_start = 0;
        n_done  = 0;
        load_pair(8'h3C, 8'hA5);
        tick();
        tick();
        tick();
        check("wait_before_done", 32'(busy), 32'd1);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("n_start_basic", 32'(n_start), 32'd1);
        check("n_done_basic", 32'(n_done), 32'd1);
        check("err_basic", 32'(err), 32'd0);

        // 10-cycle in_valid gap between A and B.
        n_start  = 0;
        n_done   = 0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        exp_q.push_back('{is_b: 1'b0, data: 8'h11});
        tick();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("gap_hold", 32'({in_ready, busy, ld_a, ld_b, op_start}), 32'b11000);
        end
        check("gap_reg_stable", 32'(reg_data), 32'h11);
        in_valid = 1'b1;
        in_data  = 8'h22;
        exp_q.push_back('{is_b: 1'b1, data: 8'h22});
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check("gap_done", 32'(done), 32'd1);
        check("gap_counts", 32'({n_start[3:0], n_done[3:0]}), 32'h11);

        // Timeout with TIMEOUT=5; err sticky until err_clr.
        n_done = 0;
        load_pair(8'h44, 8'h55);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_still_wait", 32'(busy), 32'd1);
        end
        tick();
        check("to_back_in_a", 32'(busy), 32'd0);
        check("to_err_set", 32'(err), 32'd1);
        tick();
        tick();
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_no_done", 32'(n_done), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_err_cleared", 32'(err), 32'd0);

        // err_clr on the timeout edge: set wins; one cycle later clears.
        load_pair(8'h5A, 8'hC3);
        tick();
        tick();
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        check("clr_same_edge", 32'(err), 32'd1);
        check("clr_same_edge_state", 32'(busy), 32'd0);
        tick();
        err_clr = 1'b0;
        check("clr_next_edge", 32'(err), 32'd0);

        // Reset in S_WAIT, then a late op_done.
        n_start = 0;
        n_done  = 0;
        load_pair(8'h66, 8'h77);
        tick();
        rst = 1'b1;
        tick();
        check("rst_wait_ready", 32'(in_ready), 32'd0);
        rst     = 1'b0;
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
        check("rst_wait_outs", 32'({busy, done, err, ld_a, ld_b, op_start}), 32'd0);
        check("rst_wait_reg", 32'(reg_data), 32'h00);
        check("rst_wait_no_done", 32'(n_done), 32'd0);

        // Spurious op_done in S_A, S_LDA and S_B.
        n_start = 0;
        n_done  = 0;
        op_done = 1'b1;
        tick();
        check("spur_s_a", 32'({busy, done}), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h88;
        exp_q.push_back('{is_b: 1'b0, data: 8'h88});
        tick();
        in_valid = 1'b0;
        tick();
        check("spur_s_b", 32'({in_ready, busy, done}), 32'b110);
        tick();
        check("spur_s_b_hold", 32'({in_ready, busy, done}), 32'b110);
        op_done  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h99;
        exp_q.push_back('{is_b: 1'b1, data: 8'h99});
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        tick();
        check("spur_counts", 32'({n_start[3:0], n_done[3:0]}), 32'h11);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_load_ctrl.md
OPERAND_LOAD_CTRL -- requirements
Module: operand_load_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8'd200: maximum cycles spent in S_WAIT before abort; legal range 1..255.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_data  input  8  upstream operand byte.
REQ-006 in_ready  output  1  controller accepts a byte; a transfer occurs when in_valid && in_ready on a rising edge.
REQ-007 reg_data  output  8  captured operand byte, driven to the data_in of both 8-bit operand registers.
REQ-008 ld_a  output  1  load strobe for operand register A.
REQ-009 ld_b  output  1  load strobe for operand register B.
REQ-010 op_start  output  1  one-cycle start pulse to the compute unit.
REQ-011 op_done  input  1  compute unit completion pulse.
REQ-012 done  output  1  one-cycle pulse: operation completed normally.
REQ-013 busy  output  1  high whenever the state is not S_A.
REQ-014 err  output  1  sticky timeout flag.
REQ-015 err_clr  input  1  clears err.

Function
REQ-016 The FSM SHALL have states S_A, S_LDA, S_B, S_LDB, S_GO, S_WAIT; Moore outputs decoded from state only.
REQ-017 S_A: in_ready=1; on transfer, reg_data <= in_data, next state S_LDA; otherwise stay.
REQ-018 S_LDA: in_ready=0, ld_a=1 for exactly this one cycle; next state S_B unconditionally.
REQ-019 S_B: in_ready=1; on transfer, reg_data <= in_data, next state S_LDB; otherwise stay.
REQ-020 S_LDB: in_ready=0, ld_b=1 for exactly this one cycle; next state S_GO.
REQ-021 S_GO: op_start=1 for exactly one cycle; wait_cnt (8-bit) <= 0; next state S_WAIT.
REQ-022 S_WAIT: in_ready=0; wait_cnt increments by 1 per cycle.
REQ-023 In S_WAIT, op_done=1 SHALL take priority: next state S_A, done=1 in the following cycle (registered pulse).
REQ-024 In S_WAIT, op_done=0 with wait_cnt==TIMEOUT-1: next state S_A, err <= 1, no done pulse.
REQ-025 op_done SHALL be ignored in every state other than S_WAIT.
REQ-026 reg_data SHALL change only on an accepted transfer and remain stable in S_LDA/S_LDB, so the register samples a stable byte.
REQ-027 ld_a, ld_b, op_start SHALL be mutually exclusive and never high in the same cycle.
REQ-028 Latency: byte A transfer at edge k -> ld_a high cycle k+1; byte B transfer at edge m -> ld_b high cycle m+1, op_start high cycle m+2, S_WAIT from cycle m+3.
REQ-029 err_clr=1 clears err next edge; if err_clr and a timeout occur on the same edge, err SHALL be 1 (set wins).
REQ-030 in_valid deasserted mid-sequence SHALL hold the FSM in S_A/S_B indefinitely; no timeout applies there.

Reset
REQ-031 While rst=1 at a rising edge: state <= S_A, reg_data <= 8'h00, wait_cnt <= 0, err <= 0, done <= 0.
REQ-032 in_ready SHALL be gated low while rst=1; ld_a, ld_b, op_start, busy, done SHALL be 0 in the cycle after reset.
REQ-033 Reset asserted in any state, including S_WAIT, SHALL abort without issuing ld_a, ld_b, op_start or done; a later op_done SHALL be ignored.

Verification
REQ-034 Bytes 8'h3C then 8'hA5 with in_valid held, op_done 4 cycles after op_start -> ld_a with reg_data=3C, ld_b with reg_data=A5, one op_start, done pulse once, busy low afterwards.
REQ-035 in_valid gap of 10 cycles between A and B -> FSM holds S_B, in_ready=1, no strobes; sequence resumes normally.
REQ-036 TIMEOUT=5, op_done never asserted -> return to S_A exactly 5 cycles after entering S_WAIT, err=1, no done; err stays 1 until err_clr.
REQ-037 err_clr on same edge as timeout -> err=1; err_clr one cycle later -> err=0.
REQ-038 rst pulsed in S_WAIT, then op_done -> no done, state S_A, reg_data=00, err=0.
REQ-039 Spurious op_done pulses in S_A, S_LDA, S_B -> no state change, no done.
